// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 machine-cycle sequencer.
package z80_bus_pkg;

    // Request kinds; encodings 5-7 are illegal and run as a no-op cycle.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        MEM_RD = 3'd1,
        MEM_WR = 3'd2,
        IO_RD  = 3'd3,
        IO_WR  = 3'd4
    } bus_kind_t;

    // T-states of one machine cycle.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5
    } bus_state_t;

    localparam int DEF_MEM_WAIT = 0;
    localparam int DEF_IO_WAIT  = 1;
    localparam int WAIT_CNT_W   = 3;

    function automatic logic kind_legal(input logic [2:0] k);
        return (k <= 3'd4);
    endfunction

    function automatic logic kind_mem(input logic [2:0] k);
        return (k == FETCH) || (k == MEM_RD) || (k == MEM_WR);
    endfunction

    function automatic logic kind_io(input logic [2:0] k);
        return (k == IO_RD) || (k == IO_WR);
    endfunction

    function automatic logic kind_read(input logic [2:0] k);
        return (k == FETCH) || (k == MEM_RD) || (k == IO_RD);
    endfunction

    function automatic logic kind_write(input logic [2:0] k);
        return (k == MEM_WR) || (k == IO_WR);
    endfunction

endpackage

// File: rtl/z80_refresh_ctr.sv
// Z80 R register: parallel load, 7-bit refresh increment, bit 7 preserved.
module z80_refresh_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ld,
    input  logic [7:0] i_din,
    input  logic       i_inc,
    output logic [7:0] o_r
);

    logic [7:0] r_r;

    // Load has priority over increment; only the low seven bits count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r <= 8'h00;
        end else if (i_ld) begin
            r_r <= i_din;
        end else if (i_inc) begin
            r_r <= {r_r[7], r_r[6:0] + 7'd1};
        end
    end

    assign o_r = r_r;

endmodule

// File: rtl/z80_bus_cycle_unit.sv
// Machine-cycle sequencer: turns one request into a timed T-state sequence
// on the Z80 bus strobes, with wait states and refresh.
//
// Handshake: a request transfers on any rising edge where req_valid and
// req_ready are both 1; kind/addr/wdata are captured on that edge. req_ready
// is high in IDLE and in the last T-state of a cycle, so a held req_valid
// chains cycles with no idle gap. done is a one-cycle pulse in the final
// T-state; rdata is valid with done and held until the next read capture.
//
// Every output is a register loaded from the next-state decode, so strobes
// change exactly on the edge that enters each T-state.
module z80_bus_cycle_unit
    import z80_bus_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int MEM_WAIT   = DEF_MEM_WAIT,
    parameter int IO_WAIT    = DEF_IO_WAIT,
    parameter int REFRESH_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    input  logic [7:0]        i_reg,
    input  logic              r_ld,
    input  logic [7:0]        r_din,
    output logic [7:0]        r_out,
    output logic [ADDR_W-1:0] addr_out,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic              WAIT_L,
    output logic              M1_L,
    output logic              MREQ_L,
    output logic              IORQ_L,
    output logic              RD_L,
    output logic              WR_L,
    output logic              RFSH_L,
    output logic [2:0]        dbg_state
);

    localparam bit REFRESH = (REFRESH_EN != 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MEM_INIT = WAIT_CNT_W'(MEM_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_IO_INIT  = WAIT_CNT_W'(IO_WAIT);

    bus_state_t              r_state;
    logic [2:0]              r_kind;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic                    r_ready;
    logic                    r_done;
    logic [DATA_W-1:0]       r_rdata;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_data_out;
    logic                    r_oe;
    logic                    r_m1_l, r_mreq_l, r_iorq_l, r_rd_l, r_wr_l, r_rfsh_l;

    bus_state_t              w_next_state;
    bus_state_t              w_start_state;
    logic [2:0]              w_next_kind;
    logic                    w_accept;
    logic                    w_refresh_cur;
    logic                    w_refresh_nxt;
    logic                    w_in_data_phase;
    logic [WAIT_CNT_W-1:0]   w_nxt_wait;
    logic                    w_nxt_ready;
    logic                    w_nxt_done;
    logic [DATA_W-1:0]       w_nxt_rdata;
    logic [ADDR_W-1:0]       w_nxt_addr;
    logic [DATA_W-1:0]       w_nxt_data_out;
    logic                    w_nxt_oe;
    logic                    w_nxt_m1_l, w_nxt_mreq_l, w_nxt_iorq_l;
    logic                    w_nxt_rd_l, w_nxt_wr_l, w_nxt_rfsh_l;
    logic [7:0]              w_r_val;
    logic                    w_r_ld;
    logic                    w_r_inc;

    // R only loads while idle and advances once per completed refresh.
    assign w_r_ld  = r_ld && (r_state == IDLE);
    assign w_r_inc = (r_state == T4);

    z80_refresh_ctr u_refresh_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_ld  (w_r_ld),
        .i_din (r_din),
        .i_inc (w_r_inc),
        .o_r   (w_r_val)
    );

    // Next T-state and the strobe/data values that belong to it.
    always_comb begin
        w_accept        = req_valid && r_ready;
        w_next_kind     = w_accept ? req_kind : r_kind;
        w_start_state   = kind_legal(req_kind) ? T1 : T3;
        w_refresh_cur   = REFRESH && (r_kind == FETCH);
        w_refresh_nxt   = REFRESH && (w_next_kind == FETCH);
        w_in_data_phase = (r_state == T2) || (r_state == TW);

        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = w_start_state;
            T1:      w_next_state = T2;
            T2, TW:  w_next_state = ((r_wait_cnt != '0) || !WAIT_L) ? TW : T3;
            T3: begin
                if (w_refresh_cur)  w_next_state = T4;
                else if (w_accept)  w_next_state = w_start_state;
                else                w_next_state = IDLE;
            end
            T4:      w_next_state = w_accept ? w_start_state : IDLE;
            default: w_next_state = IDLE;
        endcase

        w_nxt_m1_l     = r_m1_l;
        w_nxt_mreq_l   = r_mreq_l;
        w_nxt_iorq_l   = r_iorq_l;
        w_nxt_rd_l     = r_rd_l;
        w_nxt_wr_l     = r_wr_l;
        w_nxt_rfsh_l   = r_rfsh_l;
        w_nxt_oe       = r_oe;
        w_nxt_addr     = r_addr;
        w_nxt_data_out = r_data_out;
        w_nxt_done     = 1'b0;
        w_nxt_rdata    = r_rdata;
        w_nxt_wait     = r_wait_cnt;

        case (w_next_state)
            IDLE: begin
                w_nxt_m1_l   = 1'b1;
                w_nxt_mreq_l = 1'b1;
                w_nxt_iorq_l = 1'b1;
                w_nxt_rd_l   = 1'b1;
                w_nxt_wr_l   = 1'b1;
                w_nxt_rfsh_l = 1'b1;
                w_nxt_oe     = 1'b0;
            end
            T1: begin
                // Only reached on acceptance, so decode the incoming kind.
                w_nxt_addr   = req_addr;
                w_nxt_m1_l   = !(w_next_kind == FETCH);
                w_nxt_mreq_l = !kind_mem(w_next_kind);
                w_nxt_rd_l   = !((w_next_kind == FETCH) || (w_next_kind == MEM_RD));
                w_nxt_iorq_l = 1'b1;
                w_nxt_wr_l   = 1'b1;
                w_nxt_rfsh_l = 1'b1;
                w_nxt_oe     = kind_write(w_next_kind);
                if (kind_write(w_next_kind)) w_nxt_data_out = req_wdata;
            end
            T2: begin
                w_nxt_wait = kind_mem(r_kind) ? WAIT_MEM_INIT : WAIT_IO_INIT;
                if (kind_io(r_kind)) begin
                    w_nxt_iorq_l = 1'b0;
                    if (r_kind == IO_RD) w_nxt_rd_l = 1'b0;
                    else                 w_nxt_wr_l = 1'b0;
                end else if (r_kind == MEM_WR) begin
                    w_nxt_wr_l = 1'b0;
                end
            end
            TW: begin
                if (r_wait_cnt != '0) w_nxt_wait = r_wait_cnt - 1'b1;
            end
            T3: begin
                if (w_in_data_phase) begin
                    if (w_refresh_cur) begin
                        w_nxt_m1_l   = 1'b1;
                        w_nxt_rd_l   = 1'b1;
                        w_nxt_mreq_l = 1'b0;
                        w_nxt_rfsh_l = 1'b0;
                        w_nxt_addr   = ADDR_W'({i_reg, w_r_val});
                    end
                end else begin
                    // Illegal kind: a strobe-free single-state no-op.
                    w_nxt_m1_l   = 1'b1;
                    w_nxt_mreq_l = 1'b1;
                    w_nxt_iorq_l = 1'b1;
                    w_nxt_rd_l   = 1'b1;
                    w_nxt_wr_l   = 1'b1;
                    w_nxt_rfsh_l = 1'b1;
                    w_nxt_oe     = 1'b0;
                end
                w_nxt_done = !w_refresh_nxt;
            end
            T4: begin
                w_nxt_mreq_l = 1'b1;
                w_nxt_rfsh_l = 1'b0;
                w_nxt_done   = 1'b1;
            end
            default: ;
        endcase

        w_nxt_ready = (w_next_state == IDLE) || (w_next_state == T4) ||
                      ((w_next_state == T3) && !w_refresh_nxt);

        if (w_in_data_phase && (w_next_state == T3) && kind_read(r_kind))
            w_nxt_rdata = data_in;
    end

    // State and registered outputs; reset aborts any cycle in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_kind     <= 3'd0;
            r_wait_cnt <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_data_out <= '0;
            r_oe       <= 1'b0;
            r_m1_l     <= 1'b1;
            r_mreq_l   <= 1'b1;
            r_iorq_l   <= 1'b1;
            r_rd_l     <= 1'b1;
            r_wr_l     <= 1'b1;
            r_rfsh_l   <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_kind     <= w_next_kind;
            r_wait_cnt <= w_nxt_wait;
            r_ready    <= w_nxt_ready;
            r_done     <= w_nxt_done;
            r_rdata    <= w_nxt_rdata;
            r_addr     <= w_nxt_addr;
            r_data_out <= w_nxt_data_out;
            r_oe       <= w_nxt_oe;
            r_m1_l     <= w_nxt_m1_l;
            r_mreq_l   <= w_nxt_mreq_l;
            r_iorq_l   <= w_nxt_iorq_l;
            r_rd_l     <= w_nxt_rd_l;
            r_wr_l     <= w_nxt_wr_l;
            r_rfsh_l   <= w_nxt_rfsh_l;
        end
    end

    assign req_ready = r_ready;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign r_out     = w_r_val;
    assign addr_out  = r_addr;
    assign data_out  = r_data_out;
    assign data_oe   = r_oe;
    assign M1_L      = r_m1_l;
    assign MREQ_L    = r_mreq_l;
    assign IORQ_L    = r_iorq_l;
    assign RD_L      = r_rd_l;
    assign WR_L      = r_wr_l;
    assign RFSH_L    = r_rfsh_l;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_z80_bus_cycle_unit.sv
// Directed bench for the Z80 machine-cycle sequencer (default parameters).
module tb_z80_bus_cycle_unit;
    import z80_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_kind = 3'd0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        done;
    logic [7:0]  rdata;
    logic [7:0]  i_reg = 8'h00;
    logic        r_ld = 1'b0;
    logic [7:0]  r_din = 8'h00;
    logic [7:0]  r_out;
    logic [15:0] addr_out;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        WAIT_L = 1'b1;
    logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;
    logic [2:0]  dbg_state;
    logic [5:0]  strb;

    int n_vec  = 0;
    int n_miss = 0;

    // Strobe order: M1, MREQ, IORQ, RD, WR, RFSH
    assign strb = {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L};

    z80_bus_cycle_unit #(
        .ADDR_W(16), .DATA_W(8), .MEM_WAIT(0), .IO_WAIT(1), .REFRESH_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .rdata(rdata), .i_reg(i_reg), .r_ld(r_ld), .r_din(r_din),
        .r_out(r_out), .addr_out(addr_out), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .WAIT_L(WAIT_L),
        .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L),
        .WR_L(WR_L), .RFSH_L(RFSH_L), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (strb !== 6'b111111) begin n_miss++; $display("FAIL reset_strb got %b exp %b", strb, 6'b111111); end
        n_vec++; if ({data_oe, done, req_ready} !== 3'b001) begin n_miss++; $display("FAIL reset_ctl got %b exp 001", {data_oe, done, req_ready}); end
        n_vec++; if ({addr_out, data_out, rdata, r_out} !== 40'h0) begin n_miss++; $display("FAIL reset_data got %h exp 0", {addr_out, data_out, rdata, r_out}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mem_rd();
        req_valid = 1'b1; req_kind = 3'd1; req_addr = 16'h1234; data_in = 8'hA5; WAIT_L = 1'b1;
        tick();  // T1
        req_valid = 1'b0;
        n_vec++; if (strb !== 6'b101011) begin n_miss++; $display("FAIL memrd_t1_strb got %b exp %b", strb, 6'b101011); end
        n_vec++; if (addr_out !== 16'h1234) begin n_miss++; $display("FAIL memrd_addr got %h exp 1234", addr_out); end
        n_vec++; if ({done, req_ready} !== 2'b00) begin n_miss++; $display("FAIL memrd_t1_ctl got %b exp 00", {done, req_ready}); end
        r_ld = 1'b1; r_din = 8'h99;  // must be ignored outside IDLE
        tick();  // T2
        r_ld = 1'b0;
        n_vec++; if (r_out !== 8'h00) begin n_miss++; $display("FAIL memrd_rld_ignored got %h exp 00", r_out); end
        n_vec++; if ({strb, done} !== {6'b101011, 1'b0}) begin n_miss++; $display("FAIL memrd_t2 got %b exp 1010110", {strb, done}); end
        tick();  // T3
        n_vec++; if ({strb, done, req_ready} !== {6'b101011, 2'b11}) begin n_miss++; $display("FAIL memrd_t3 got %b exp 10101111", {strb, done, req_ready}); end
        n_vec++; if (rdata !== 8'hA5) begin n_miss++; $display("FAIL memrd_rdata got %h exp a5", rdata); end
        tick();  // IDLE
        n_vec++; if ({strb, done} !== 7'b1111110) begin n_miss++; $display("FAIL memrd_end got %b exp 1111110", {strb, done}); end
    endtask

    task automatic test_fetch();
        r_ld = 1'b1; r_din = 8'h7F;
        tick();
        r_ld = 1'b0;
        n_vec++; if (r_out !== 8'h7F) begin n_miss++; $display("FAIL fetch_rload got %h exp 7f", r_out); end
        req_valid = 1'b1; req_kind = 3'd0; req_addr = 16'h0000; i_reg = 8'h3C; data_in = 8'h3E;
        tick();  // T1
        req_valid = 1'b0;
        n_vec++; if (strb !== 6'b001011) begin n_miss++; $display("FAIL fetch_t1_strb got %b exp %b", strb, 6'b001011); end
        tick();  // T2
        n_vec++; if (strb !== 6'b001011) begin n_miss++; $display("FAIL fetch_t2_strb got %b exp %b", strb, 6'b001011); end
        tick();  // T3 refresh
        n_vec++; if (strb !== 6'b101110) begin n_miss++; $display("FAIL fetch_t3_strb got %b exp %b", strb, 6'b101110); end
        n_vec++; if (addr_out !== 16'h3C7F) begin n_miss++; $display("FAIL fetch_rfsh_addr got %h exp 3c7f", addr_out); end
        n_vec++; if ({done, req_ready, rdata} !== {2'b00, 8'h3E}) begin n_miss++; $display("FAIL fetch_t3_ctl got %h exp 03e", {done, req_ready, rdata}); end
        tick();  // T4
        n_vec++; if ({strb, done, req_ready} !== {6'b111110, 2'b11}) begin n_miss++; $display("FAIL fetch_t4 got %b exp 11111011", {strb, done, req_ready}); end
        tick();  // IDLE
        n_vec++; if (r_out !== 8'h00) begin n_miss++; $display("FAIL fetch_r_wrap got %h exp 00", r_out); end
        n_vec++; if ({strb, done} !== 7'b1111110) begin n_miss++; $display("FAIL fetch_end got %b exp 1111110", {strb, done}); end
    endtask

    task automatic test_io_wr_waits();
        int done_cyc = 0;
        int tw_cnt   = 0;
        int oe_bad   = 0;
        logic [5:0] t2_strb = 6'b000000;
        req_valid = 1'b1; req_kind = 3'd4; req_addr = 16'h00FE; req_wdata = 8'h55; WAIT_L = 1'b1;
        tick();  // T1 is cycle 1
        req_valid = 1'b0;
        n_vec++; if ({strb, data_out, addr_out} !== {6'b111111, 8'h55, 16'h00FE}) begin n_miss++; $display("FAIL iowr_t1 got %h exp 3f5500fe", {strb, data_out, addr_out}); end
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            if (data_oe !== 1'b1) oe_bad++;
            if (dbg_state == TW) tw_cnt++;
            if (c == 2) t2_strb = strb;
            if (done === 1'b1) begin
                done_cyc = c;
            end else begin
                WAIT_L = (c == 2 || c == 3) ? 1'b0 : 1'b1;
                tick();
            end
        end
        n_vec++; if (done_cyc != 5) begin n_miss++; $display("FAIL iowr_done_cycle got %0d exp 5", done_cyc); end
        n_vec++; if (tw_cnt != 2) begin n_miss++; $display("FAIL iowr_tw_count got %0d exp 2", tw_cnt); end
        n_vec++; if (oe_bad != 0) begin n_miss++; $display("FAIL iowr_data_oe got %0d low cycles exp 0", oe_bad); end
        n_vec++; if (t2_strb !== 6'b110101) begin n_miss++; $display("FAIL iowr_t2_strb got %b exp %b", t2_strb, 6'b110101); end
        n_vec++; if (strb !== 6'b110101) begin n_miss++; $display("FAIL iowr_t3_strb got %b exp %b", strb, 6'b110101); end
        WAIT_L = 1'b1;
        tick();
        n_vec++; if ({strb, data_oe} !== 7'b1111110) begin n_miss++; $display("FAIL iowr_end got %b exp 1111110", {strb, data_oe}); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] wr_seq   = '0;
        logic [6:0] mreq_seq = '0;
        logic [6:0] done_seq = '0;
        logic [6:0] oe_seq   = '0;
        logic [2:0] st_b1    = 3'd0;
        logic [23:0] ad_b1   = '0;
        req_valid = 1'b1; req_kind = 3'd2; req_addr = 16'h4000; req_wdata = 8'h11;
        tick();  // T1 of first
        req_addr = 16'h4001; req_wdata = 8'h22;
        for (int i = 0; i < 7; i++) begin
            wr_seq[i]   = WR_L;
            mreq_seq[i] = MREQ_L;
            done_seq[i] = done;
            oe_seq[i]   = data_oe;
            if (i == 3) begin
                st_b1 = dbg_state;
                ad_b1 = {addr_out, data_out};
                req_valid = 1'b0;
            end
            if (i < 6) tick();
        end
        n_vec++; if (wr_seq !== 7'b1001001) begin n_miss++; $display("FAIL b2b_wr_seq got %b exp 1001001", wr_seq); end
        n_vec++; if (mreq_seq !== 7'b1000000) begin n_miss++; $display("FAIL b2b_mreq_seq got %b exp 1000000", mreq_seq); end
        n_vec++; if (done_seq !== 7'b0100100) begin n_miss++; $display("FAIL b2b_done_seq got %b exp 0100100", done_seq); end
        n_vec++; if (oe_seq !== 7'b0111111) begin n_miss++; $display("FAIL b2b_oe_seq got %b exp 0111111", oe_seq); end
        n_vec++; if (st_b1 !== 3'd1) begin n_miss++; $display("FAIL b2b_no_gap got state %0d exp 1", st_b1); end
        n_vec++; if (ad_b1 !== 24'h400122) begin n_miss++; $display("FAIL b2b_second_req got %h exp 400122", ad_b1); end
    endtask

    task automatic test_illegal();
        req_valid = 1'b1; req_kind = 3'd5; req_addr = 16'h5555;
        tick();
        req_valid = 1'b0;
        n_vec++; if ({strb, data_oe, done, req_ready} !== {6'b111111, 3'b011}) begin n_miss++; $display("FAIL illegal_noop got %b exp 111111011", {strb, data_oe, done, req_ready}); end
        tick();
        n_vec++; if ({done, dbg_state} !== 4'b0000) begin n_miss++; $display("FAIL illegal_end got %b exp 0000", {done, dbg_state}); end
    endtask

    task automatic test_rld_fetch();
        r_ld = 1'b1; r_din = 8'hFF;
        req_valid = 1'b1; req_kind = 3'd0; req_addr = 16'h0100; i_reg = 8'h3C;
        tick();  // T1
        r_ld = 1'b0; req_valid = 1'b0;
        n_vec++; if (r_out !== 8'hFF) begin n_miss++; $display("FAIL rld_load_wins got %h exp ff", r_out); end
        tick();  // T2
        tick();  // T3
        n_vec++; if ({addr_out, RFSH_L} !== {16'h3CFF, 1'b0}) begin n_miss++; $display("FAIL rld_rfsh_addr got %h exp 3cff/0", {addr_out, RFSH_L}); end
        tick();  // T4
        tick();  // IDLE
        n_vec++; if (r_out !== 8'h80) begin n_miss++; $display("FAIL rld_bit7_hold got %h exp 80", r_out); end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_kind = 3'd3; req_addr = 16'h0010; WAIT_L = 1'b1;
        tick();  // T1
        req_valid = 1'b0; WAIT_L = 1'b0;
        tick();  // T2
        tick();  // TW
        n_vec++; if ({dbg_state, strb} !== {3'd3, 6'b110011}) begin n_miss++; $display("FAIL rstmid_tw got %b exp 011110011", {dbg_state, strb}); end
        rst = 1'b1;
        tick();
        n_vec++; if ({strb, data_oe, done, req_ready} !== {6'b111111, 3'b001}) begin n_miss++; $display("FAIL rstmid_abort got %b exp 111111001", {strb, data_oe, done, req_ready}); end
        n_vec++; if ({dbg_state, r_out, rdata} !== 19'h0) begin n_miss++; $display("FAIL rstmid_regs got %h exp 0", {dbg_state, r_out, rdata}); end
        rst = 1'b0; WAIT_L = 1'b1;
        tick();
        n_vec++; if ({done, strb} !== 7'b0111111) begin n_miss++; $display("FAIL rstmid_no_done got %b exp 0111111", {done, strb}); end
    endtask

    initial begin
        test_reset();
        test_mem_rd();
        test_fetch();
        test_io_wr_waits();
        test_back_to_back();
        test_illegal();
        test_rld_fetch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
